// File: rtl/fsmc_slave_ctrl.sv
// FSMC asynchronous SRAM-style slave: strobe synchronizers, cycle decode and register-bus handshake.
// Optional read-acknowledge timeout is compiled in when FSMC_RD_TIMEOUT_EN is defined.
`ifndef FSMC_WIDTH
`define FSMC_WIDTH 16
`endif

module fsmc_slave_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int WR_DLY     = 2,
    parameter int RD_TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fsmc_ne,
    input  logic                   fsmc_noe,
    input  logic                   fsmc_nwe,
    input  logic [ADDR_WIDTH-1:0]  fsmc_addr,
    input  logic [`FSMC_WIDTH-1:0] bus_din,
    output logic [`FSMC_WIDTH-1:0] bus_dout,
    output logic                   bus_oe,
    output logic [ADDR_WIDTH-1:0]  reg_addr,
    output logic [`FSMC_WIDTH-1:0] reg_wdata,
    output logic                   reg_wr,
    output logic                   reg_rd,
    input  logic [`FSMC_WIDTH-1:0] reg_rdata,
    input  logic                   reg_rack,
    output logic                   proto_err
);

    // state      | meaning
    // S_IDLE     | no cycle in progress, watching for strobe edges
    // S_WR_WAIT  | NWE low, counting down to the write sample point
    // S_WR_HOLD  | write issued, waiting for NWE to return high
    // S_RD_REQ   | reg_rd issued, waiting for reg_rack (or timeout)
    // S_RD_DRIVE | read data loaded, driving the pads until NOE rises
    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_WAIT,
        S_WR_HOLD,
        S_RD_REQ,
        S_RD_DRIVE
    } state_t;

    state_t                   r_state;
    logic                     r_ne_m,  r_ne_s;
    logic                     r_noe_m, r_noe_s, r_noe_d;
    logic                     r_nwe_m, r_nwe_s, r_nwe_d;
    logic [2:0]               r_wr_cnt;
    logic                     r_perr_armed;
    logic [ADDR_WIDTH-1:0]    r_reg_addr;
    logic [`FSMC_WIDTH-1:0]   r_reg_wdata;
    logic [`FSMC_WIDTH-1:0]   r_bus_dout;
    logic                     r_reg_wr;
    logic                     r_reg_rd;
    logic                     r_bus_oe;
    logic                     r_proto_err;

    logic                     w_noe_fall;
    logic                     w_nwe_fall;
    logic                     w_illegal;
    logic                     w_rd_timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ne_m  <= 1'b1;
            r_ne_s  <= 1'b1;
            r_noe_m <= 1'b1;
            r_noe_s <= 1'b1;
            r_noe_d <= 1'b1;
            r_nwe_m <= 1'b1;
            r_nwe_s <= 1'b1;
            r_nwe_d <= 1'b1;
        end else begin
            r_ne_m  <= fsmc_ne;
            r_ne_s  <= r_ne_m;
            r_noe_m <= fsmc_noe;
            r_noe_s <= r_noe_m;
            r_noe_d <= r_noe_s;
            r_nwe_m <= fsmc_nwe;
            r_nwe_s <= r_nwe_m;
            r_nwe_d <= r_nwe_s;
        end
    end

    assign w_noe_fall = r_noe_d & ~r_noe_s;
    assign w_nwe_fall = r_nwe_d & ~r_nwe_s;
    assign w_illegal  = ~r_ne_s & ~r_noe_s & ~r_nwe_s;

`ifdef FSMC_RD_TIMEOUT_EN
    localparam int TO_W = $clog2(RD_TIMEOUT + 1);

    logic [TO_W-1:0] r_to_cnt;

    // Held at zero outside RD_REQ, so every read request starts a fresh count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (r_state != S_RD_REQ) begin
            r_to_cnt <= '0;
        end else if (!w_rd_timeout) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign w_rd_timeout = (r_to_cnt == TO_W'(RD_TIMEOUT - 1));
`else
    logic w_unused_rd_timeout;

    assign w_rd_timeout        = 1'b0;
    assign w_unused_rd_timeout = (RD_TIMEOUT != 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_wr_cnt     <= '0;
            r_perr_armed <= 1'b1;
            r_reg_addr   <= '0;
            r_reg_wdata  <= '0;
            r_bus_dout   <= '0;
            r_reg_wr     <= 1'b0;
            r_reg_rd     <= 1'b0;
            r_bus_oe     <= 1'b0;
            r_proto_err  <= 1'b0;
        end else begin
            r_reg_wr    <= 1'b0;
            r_reg_rd    <= 1'b0;
            r_bus_oe    <= 1'b0;
            r_proto_err <= 1'b0;

            if (r_noe_s && r_nwe_s) begin
                r_perr_armed <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_illegal) begin
                        if (r_perr_armed) begin
                            r_proto_err  <= 1'b1;
                            r_perr_armed <= 1'b0;
                        end
                    end else if (!r_ne_s && w_nwe_fall && r_noe_s) begin
                        r_wr_cnt <= 3'(WR_DLY);
                        r_state  <= S_WR_WAIT;
                    end else if (!r_ne_s && w_noe_fall && r_nwe_s) begin
                        r_reg_addr <= fsmc_addr;
                        r_reg_rd   <= 1'b1;
                        r_state    <= S_RD_REQ;
                    end
                end

                S_WR_WAIT: begin
                    if (r_ne_s) begin
                        r_state <= S_IDLE;
                    end else if (r_wr_cnt == 3'd0) begin
                        r_reg_addr  <= fsmc_addr;
                        r_reg_wdata <= bus_din;
                        r_reg_wr    <= 1'b1;
                        r_state     <= S_WR_HOLD;
                    end else begin
                        r_wr_cnt <= r_wr_cnt - 3'd1;
                    end
                end

                S_WR_HOLD: begin
                    if (r_ne_s || r_nwe_s) begin
                        r_state <= S_IDLE;
                    end
                end

                S_RD_REQ: begin
                    if (r_ne_s) begin
                        r_state <= S_IDLE;
                    end else if (reg_rack) begin
                        r_bus_dout <= reg_rdata;
                        r_state    <= S_RD_DRIVE;
                    end else if (w_rd_timeout) begin
                        r_bus_dout  <= '1;
                        r_proto_err <= 1'b1;
                        r_state     <= S_RD_DRIVE;
                    end
                end

                // bus_oe is registered off this state, so it trails bus_dout by one clock.
                S_RD_DRIVE: begin
                    if (r_ne_s || r_noe_s) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_bus_oe <= 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus_dout  = r_bus_dout;
    assign bus_oe    = r_bus_oe;
    assign reg_addr  = r_reg_addr;
    assign reg_wdata = r_reg_wdata;
    assign reg_wr    = r_reg_wr;
    assign reg_rd    = r_reg_rd;
    assign proto_err = r_proto_err;

endmodule

// File: tb/tb_fsmc_slave_ctrl.sv
// Bench for fsmc_slave_ctrl: directed scenarios plus randomized write/read transactions
// checked against transaction-level expectations.
`ifndef FSMC_WIDTH
`define FSMC_WIDTH 16
`endif

module tb_fsmc_slave_ctrl;

    localparam int AW       = 8;
    localparam int DW       = `FSMC_WIDTH;
    localparam int WR_DLY_A = 2;
    localparam int WR_DLY_B = 7;
    localparam int RD_TO    = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          fsmc_ne, fsmc_noe, fsmc_nwe;
    logic [AW-1:0] fsmc_addr;
    logic [DW-1:0] bus_din;
    logic [DW-1:0] reg_rdata;
    logic          reg_rack;

    logic [DW-1:0] bus_dout,  bus_dout_b;
    logic          bus_oe,    bus_oe_b;
    logic [AW-1:0] reg_addr,  reg_addr_b;
    logic [DW-1:0] reg_wdata, reg_wdata_b;
    logic          reg_wr,    reg_wr_b;
    logic          reg_rd,    reg_rd_b;
    logic          proto_err, proto_err_b;

    int errors = 0;
    int checks = 0;

    int            wr_cnt = 0, rd_cnt = 0, perr_cnt = 0, oe_cnt = 0, wrb_cnt = 0;
    logic [AW-1:0] wr_addr, wrb_addr;
    logic [DW-1:0] wr_data, wrb_data;
    logic [DW-1:0] exp_dout;

    fsmc_slave_ctrl #(.ADDR_WIDTH(AW), .WR_DLY(WR_DLY_A), .RD_TIMEOUT(RD_TO)) dut (
        .clk(clk), .rst(rst),
        .fsmc_ne(fsmc_ne), .fsmc_noe(fsmc_noe), .fsmc_nwe(fsmc_nwe), .fsmc_addr(fsmc_addr),
        .bus_din(bus_din), .bus_dout(bus_dout), .bus_oe(bus_oe),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
        .reg_rdata(reg_rdata), .reg_rack(reg_rack), .proto_err(proto_err)
    );

    fsmc_slave_ctrl #(.ADDR_WIDTH(AW), .WR_DLY(WR_DLY_B), .RD_TIMEOUT(RD_TO)) dut_b (
        .clk(clk), .rst(rst),
        .fsmc_ne(fsmc_ne), .fsmc_noe(fsmc_noe), .fsmc_nwe(fsmc_nwe), .fsmc_addr(fsmc_addr),
        .bus_din(bus_din), .bus_dout(bus_dout_b), .bus_oe(bus_oe_b),
        .reg_addr(reg_addr_b), .reg_wdata(reg_wdata_b), .reg_wr(reg_wr_b), .reg_rd(reg_rd_b),
        .reg_rdata(reg_rdata), .reg_rack(reg_rack), .proto_err(proto_err_b)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reg_wr) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= reg_addr;
            wr_data <= reg_wdata;
        end
        if (reg_wr_b) begin
            wrb_cnt  <= wrb_cnt + 1;
            wrb_addr <= reg_addr_b;
            wrb_data <= reg_wdata_b;
        end
        if (reg_rd)    rd_cnt   <= rd_cnt + 1;
        if (proto_err) perr_cnt <= perr_cnt + 1;
        if (bus_oe)    oe_cnt   <= oe_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus: one host write cycle; lat = negedge index of the first reg_wr, -1 if none.
    task automatic drive_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input int len, output int lat);
        lat = -1;
        @(negedge clk);
        fsmc_addr = a;
        bus_din   = d;
        fsmc_ne   = 1'b0;
        fsmc_nwe  = 1'b0;
        for (int k = 1; k <= len + 4; k++) begin
            if (k == len + 1) fsmc_nwe = 1'b1;
            @(negedge clk);
            if (reg_wr && lat < 0) lat = k;
        end
        fsmc_ne = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic start_read(input logic [AW-1:0] a, output int lat);
        lat = -1;
        @(negedge clk);
        fsmc_addr = a;
        fsmc_ne   = 1'b0;
        fsmc_noe  = 1'b0;
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            @(negedge clk);
            if (reg_rd) lat = k;
        end
    endtask

    task automatic ack_read(input int dly, input logic [DW-1:0] d);
        repeat (dly) @(negedge clk);
        reg_rdata = d;
        reg_rack  = 1'b1;
        @(negedge clk);
        reg_rack  = 1'b0;
    endtask

    task automatic end_read(output int fall);
        fall = -1;
        fsmc_noe = 1'b1;
        for (int k = 1; k <= 10 && fall < 0; k++) begin
            @(negedge clk);
            if (!bus_oe) fall = k;
        end
        fsmc_ne = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({bus_oe, reg_wr, reg_rd, proto_err, bus_dout, reg_addr, reg_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got oe=%b wr=%b rd=%b perr=%b dout=%h addr=%h wdata=%h required all 0",
                     bus_oe, reg_wr, reg_rd, proto_err, bus_dout, reg_addr, reg_wdata);
        end
        checks++;
        if ({bus_oe_b, reg_wr_b, reg_rd_b, proto_err_b, bus_dout_b, reg_addr_b, reg_wdata_b} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_b: got nonzero outputs on second instance, required all 0");
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_write();
        int lat;
        int w0 = wr_cnt, r0 = rd_cnt, o0 = oe_cnt;
        drive_write(8'h12, DW'(16'hA5C3), 10, lat);
        checks++;
        if (lat != 4 + WR_DLY_A) begin
            errors++; $display("FAIL wr_latency: got %0d required %0d", lat, 4 + WR_DLY_A);
        end
        checks++;
        if (wr_cnt - w0 != 1) begin
            errors++; $display("FAIL wr_count: got %0d required 1", wr_cnt - w0);
        end
        checks++;
        if (wr_addr !== 8'h12 || wr_data !== DW'(16'hA5C3)) begin
            errors++; $display("FAIL wr_payload: got addr=%h data=%h required 12/A5C3", wr_addr, wr_data);
        end
        checks++;
        if (oe_cnt != o0 || rd_cnt != r0) begin
            errors++; $display("FAIL wr_side_effects: got oe_cycles=%0d rd=%0d required 0/0", oe_cnt - o0, rd_cnt - r0);
        end
    endtask

    task automatic test_read();
        int lat, fall, bad;
        int w0 = wr_cnt, r0 = rd_cnt;
        start_read(8'h34, lat);
        checks++;
        if (lat != 3 || reg_addr !== 8'h34) begin
            errors++; $display("FAIL rd_request: got lat=%0d addr=%h required 3/34", lat, reg_addr);
        end
        ack_read(3, DW'(16'h1357));
        checks++;
        if (bus_dout !== DW'(16'h1357) || bus_oe !== 1'b0) begin
            errors++; $display("FAIL rd_dout: got dout=%h oe=%b required 1357/0", bus_dout, bus_oe);
        end
        @(negedge clk);
        checks++;
        if (bus_oe !== 1'b1) begin
            errors++; $display("FAIL rd_oe_rise: got %b required 1", bus_oe);
        end
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus_oe !== 1'b1 || bus_dout !== DW'(16'h1357)) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL rd_oe_hold: got %0d bad cycles required 0", bad);
        end
        end_read(fall);
        checks++;
        if (fall < 1 || fall > 4) begin
            errors++; $display("FAIL rd_oe_fall: got %0d clocks required 1..4", fall);
        end
        checks++;
        if (wr_cnt != w0 || rd_cnt - r0 != 1 || bus_dout !== DW'(16'h1357)) begin
            errors++; $display("FAIL rd_counts: got wr=%0d rd=%0d dout=%h required 0/1/1357",
                               wr_cnt - w0, rd_cnt - r0, bus_dout);
        end
        exp_dout = DW'(16'h1357);
    endtask

    task automatic test_illegal();
        int w0 = wr_cnt, r0 = rd_cnt, p0 = perr_cnt, o0 = oe_cnt;
        for (int ep = 1; ep <= 2; ep++) begin
            @(negedge clk);
            fsmc_addr = 8'h55;
            fsmc_ne   = 1'b0;
            fsmc_noe  = 1'b0;
            fsmc_nwe  = 1'b0;
            repeat (8) @(negedge clk);
            fsmc_noe = 1'b1;
            fsmc_nwe = 1'b1;
            repeat (4) @(negedge clk);
            fsmc_ne = 1'b1;
            repeat (4) @(negedge clk);
            checks++;
            if (perr_cnt - p0 != ep) begin
                errors++; $display("FAIL illegal_perr: episode %0d got %0d pulse cycles required %0d", ep, perr_cnt - p0, ep);
            end
        end
        checks++;
        if (wr_cnt != w0 || rd_cnt != r0 || oe_cnt != o0) begin
            errors++; $display("FAIL illegal_access: got wr=%0d rd=%0d oe=%0d required 0/0/0",
                               wr_cnt - w0, rd_cnt - r0, oe_cnt - o0);
        end
    endtask

    task automatic test_abort();
        int lat;
        int w0 = wr_cnt, b0 = wrb_cnt, o0 = oe_cnt;
        @(negedge clk);
        fsmc_addr = 8'h66;
        bus_din   = DW'(16'hBEEF);
        fsmc_ne   = 1'b0;
        fsmc_nwe  = 1'b0;
        repeat (2) @(negedge clk);
        fsmc_ne = 1'b1;
        repeat (12) @(negedge clk);
        fsmc_nwe = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (wr_cnt != w0 || wrb_cnt != b0 || oe_cnt != o0) begin
            errors++; $display("FAIL abort_write: got wr=%0d wr_b=%0d oe=%0d required 0/0/0",
                               wr_cnt - w0, wrb_cnt - b0, oe_cnt - o0);
        end
        drive_write(8'h77, DW'(16'h0F1E), 14, lat);
        checks++;
        if (wr_cnt - w0 != 1 || wr_addr !== 8'h77 || wr_data !== DW'(16'h0F1E)) begin
            errors++; $display("FAIL abort_next_write: got n=%0d addr=%h data=%h required 1/77/0F1E",
                               wr_cnt - w0, wr_addr, wr_data);
        end
        checks++;
        if (wrb_cnt - b0 != 1 || wrb_addr !== 8'h77 || wrb_data !== DW'(16'h0F1E)) begin
            errors++; $display("FAIL abort_next_write_b: got n=%0d addr=%h data=%h required 1/77/0F1E",
                               wrb_cnt - b0, wrb_addr, wrb_data);
        end
    endtask

    task automatic test_read_abort();
        int lat;
        int r0 = rd_cnt, p0 = perr_cnt, o0 = oe_cnt;
        start_read(8'h9A, lat);
        repeat (20) @(negedge clk);
        fsmc_ne  = 1'b1;
        fsmc_noe = 1'b1;
        repeat (5) @(negedge clk);
        ack_read(0, DW'(16'hDEAD));
        repeat (3) @(negedge clk);
        checks++;
        if (bus_dout !== exp_dout || oe_cnt != o0 || perr_cnt != p0) begin
            errors++; $display("FAIL read_abort: got dout=%h oe=%0d perr=%0d required %h/0/0",
                               bus_dout, oe_cnt - o0, perr_cnt - p0, exp_dout);
        end
        checks++;
        if (lat < 0 || rd_cnt - r0 != 1) begin
            errors++; $display("FAIL read_abort_req: got lat=%0d rd=%0d required >0/1", lat, rd_cnt - r0);
        end
    endtask

    task automatic test_reset_mid_read();
        int lat, fall;
        logic [DW-1:0] d;
        start_read(8'hC4, lat);
        ack_read(1, DW'(16'h2468));
        @(negedge clk);
        checks++;
        if (bus_oe !== 1'b1) begin
            errors++; $display("FAIL rst_pre_oe: got %b required 1", bus_oe);
        end
        #2;
        rst      = 1'b1;
        fsmc_ne  = 1'b1;
        fsmc_noe = 1'b1;
        #1;
        checks++;
        if ({bus_oe, reg_wr, reg_rd, proto_err, bus_dout, reg_addr, reg_wdata} !== '0) begin
            errors++; $display("FAIL rst_async: got oe=%b dout=%h addr=%h wdata=%h required all 0",
                               bus_oe, bus_dout, reg_addr, reg_wdata);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        d = DW'($urandom);
        start_read(8'h01, lat);
        checks++;
        if (lat != 3 || reg_addr !== 8'h01) begin
            errors++; $display("FAIL rst_read_req: got lat=%0d addr=%h required 3/01", lat, reg_addr);
        end
        ack_read(2, d);
        @(negedge clk);
        checks++;
        if (bus_dout !== d || bus_oe !== 1'b1) begin
            errors++; $display("FAIL rst_read_data: got dout=%h oe=%b required %h/1", bus_dout, bus_oe, d);
        end
        end_read(fall);
        exp_dout = d;
    endtask

`ifdef FSMC_RD_TIMEOUT_EN
    task automatic test_timeout();
        int lat, k_err, fall, bad;
        start_read(8'h3C, lat);
        k_err = -1;
        for (int k = 1; k <= 200 && k_err < 0; k++) begin
            @(negedge clk);
            if (proto_err) k_err = k;
        end
        checks++;
        if (k_err != RD_TO) begin
            errors++; $display("FAIL timeout_latency: got %0d required %0d", k_err, RD_TO);
        end
        checks++;
        if (bus_dout !== '1 || bus_oe !== 1'b0) begin
            errors++; $display("FAIL timeout_dout: got dout=%h oe=%b required all-ones/0", bus_dout, bus_oe);
        end
        @(negedge clk);
        checks++;
        if (bus_oe !== 1'b1 || proto_err !== 1'b0) begin
            errors++; $display("FAIL timeout_oe: got oe=%b perr=%b required 1/0", bus_oe, proto_err);
        end
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus_oe !== 1'b1) bad++;
        end
        end_read(fall);
        checks++;
        if (bad != 0 || fall < 1 || fall > 4) begin
            errors++; $display("FAIL timeout_release: got bad=%0d fall=%0d required 0/1..4", bad, fall);
        end
        exp_dout = '1;
    endtask
`endif

    task automatic test_random();
        int lat, fall, len, dly;
        int w0, r0;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        for (int n = 0; n < 24; n++) begin
            a  = AW'($urandom);
            d  = DW'($urandom);
            w0 = wr_cnt;
            r0 = rd_cnt;
            if ($urandom_range(0, 1) == 0) begin
                len = int'($urandom_range(WR_DLY_A + 5, WR_DLY_A + 12));
                drive_write(a, d, len, lat);
                checks++;
                if (lat != 4 + WR_DLY_A || wr_cnt - w0 != 1 || rd_cnt != r0) begin
                    errors++; $display("FAIL rand_wr_count[%0d]: got lat=%0d wr=%0d rd=%0d required %0d/1/0",
                                       n, lat, wr_cnt - w0, rd_cnt - r0, 4 + WR_DLY_A);
                end
                checks++;
                if (wr_addr !== a || wr_data !== d) begin
                    errors++; $display("FAIL rand_wr_payload[%0d]: got %h/%h required %h/%h", n, wr_addr, wr_data, a, d);
                end
            end else begin
                dly = int'($urandom_range(0, 5));
                start_read(a, lat);
                checks++;
                if (lat != 3 || reg_addr !== a) begin
                    errors++; $display("FAIL rand_rd_req[%0d]: got lat=%0d addr=%h required 3/%h", n, lat, reg_addr, a);
                end
                ack_read(dly, d);
                checks++;
                if (bus_dout !== d || bus_oe !== 1'b0) begin
                    errors++; $display("FAIL rand_rd_dout[%0d]: got %h/%b required %h/0", n, bus_dout, bus_oe, d);
                end
                @(negedge clk);
                checks++;
                if (bus_oe !== 1'b1) begin
                    errors++; $display("FAIL rand_rd_oe[%0d]: got %b required 1", n, bus_oe);
                end
                end_read(fall);
                checks++;
                if (fall < 1 || fall > 4 || wr_cnt != w0 || rd_cnt - r0 != 1) begin
                    errors++; $display("FAIL rand_rd_end[%0d]: got fall=%0d wr=%0d rd=%0d required 1..4/0/1",
                                       n, fall, wr_cnt - w0, rd_cnt - r0);
                end
                exp_dout = d;
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        fsmc_ne   = 1'b1;
        fsmc_noe  = 1'b1;
        fsmc_nwe  = 1'b1;
        fsmc_addr = '0;
        bus_din   = '0;
        reg_rdata = '0;
        reg_rack  = 1'b0;
        exp_dout  = '0;

        test_reset();
        test_write();
        test_read();
        test_illegal();
        test_abort();
        test_read_abort();
        test_reset_mid_read();
`ifdef FSMC_RD_TIMEOUT_EN
        test_timeout();
`endif
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fsmc_slave_ctrl.md
Name: fsmc_slave_ctrl

Overview:
Control stage for the FSMC external-memory interface. It sits between the STM32 FSMC asynchronous SRAM-style strobes and the internal register bus. On the data side it pairs with the bidirectional pad buffer: it consumes the buffer's registered pin data (`bus_din`) and produces the buffer's output enable (`bus_oe`) and read data (`bus_dout`). It synchronizes the strobes, decodes write and read cycles, and runs a request/acknowledge handshake with the register file.

Parameters:
ADDR_WIDTH, 8, width of fsmc_addr and reg_addr
WR_DLY, 2, cycles after synchronized NWE falling edge before write address/data are sampled (range 0-7)
RD_TIMEOUT, 64, cycles to wait for reg_rack before forcing completion (used only with FSMC_RD_TIMEOUT_EN)

Ports:
clk  input  1  system clock; the only clock
rst  input  1  asynchronous, active-high reset
fsmc_ne  input  1  FSMC chip select, active-low, asynchronous to clk
fsmc_noe  input  1  FSMC output enable, active-low, asynchronous
fsmc_nwe  input  1  FSMC write enable, active-low, asynchronous
fsmc_addr  input  ADDR_WIDTH  FSMC address pins
bus_din  input  `FSMC_WIDTH  registered pin data from the pad buffer
bus_dout  output  `FSMC_WIDTH  read data to the pad buffer's input
bus_oe  output  1  pad buffer output enable
reg_addr  output  ADDR_WIDTH  register bus address
reg_wdata  output  `FSMC_WIDTH  register write data
reg_wr  output  1  one-cycle write strobe
reg_rd  output  1  one-cycle read request strobe
reg_rdata  input  `FSMC_WIDTH  register read data, valid with reg_rack
reg_rack  input  1  read acknowledge, one-cycle pulse
proto_err  output  1  one-cycle pulse on protocol violation

Behaviour:
- Synchronizers: ne, noe and nwe each pass through a 2-FF synchronizer, reset to 1. All decoding uses the synchronized values (ne_s, noe_s, nwe_s). Edges are detected against a third, delayed stage.
- fsmc_addr is sampled directly. It must be stable whenever a strobe is low (FSMC ADDSET/DATAST are configured for this).
- Reset (async, any time, including mid-cycle):
  - bus_oe=0, bus_dout=0, reg_addr=0, reg_wdata=0, reg_wr=0, reg_rd=0, proto_err=0.
  - State = IDLE; synchronizers are all 1.
- IDLE:
  - ne_s=0 with a nwe_s falling edge and noe_s=1 -> WR_WAIT; load delay counter with WR_DLY.
  - ne_s=0 with a noe_s falling edge and nwe_s=1 -> RD_REQ; latch reg_addr<=fsmc_addr; pulse reg_rd for one cycle (the cycle after the edge is detected).
  - noe_s=0 and nwe_s=0 together with ne_s=0 -> proto_err pulse for one cycle; remain IDLE; no register access. The pulse re-arms only after both strobes return high.
- WR_WAIT:
  - Counter decrements each cycle. When it hits 0: reg_addr<=fsmc_addr, reg_wdata<=bus_din, reg_wr=1 for exactly one cycle -> WR_HOLD.
  - With WR_DLY=0, sampling occurs in the cycle after the edge is detected.
- WR_HOLD: wait for nwe_s=1 -> IDLE. Exactly one reg_wr is issued per NWE low pulse.
- RD_REQ:
  - Wait for reg_rack. On reg_rack: bus_dout<=reg_rdata -> RD_DRIVE.
  - reg_rack in the same cycle as the reg_rd pulse is legal.
  - reg_rack while not in RD_REQ is ignored.
- RD_DRIVE:
  - bus_oe=1 from the first cycle in this state. This is one cycle after bus_dout is loaded, which allows for the pad buffer's input register.
  - noe_s=1 -> bus_oe=0 on the next clock edge; bus_dout holds its value -> IDLE.
- Abort: in any non-IDLE state, ne_s=1 -> IDLE next cycle and bus_oe=0.
  - A pending write in WR_WAIT is dropped with no reg_wr.
  - A pending read drops its wait; a later reg_rack is ignored.
- bus_oe is never 1 outside RD_DRIVE.
- Read-to-pins latency from reg_rack: bus_oe and pad data are valid 2 clk later at the pins. Host DATAST must cover 2 sync + 1 reg_rd + register latency + 2 clk.

Optional Feature:
FSMC_RD_TIMEOUT_EN
- Defined:
  - RD_REQ runs a counter. If reg_rack is absent for RD_TIMEOUT cycles, bus_dout<={`FSMC_WIDTH{1'b1}}, proto_err pulses one cycle, and the state goes to RD_DRIVE.
  - The counter is cleared on entry to RD_REQ.
- Undefined: no counter is instantiated and RD_REQ waits indefinitely; abort still applies.

Test Plan:
- Write: ne=0, addr=8'h12, bus_din=16'hA5C3, nwe low 10 clk, WR_DLY=2 -> exactly one reg_wr with reg_addr=12, reg_wdata=A5C3; bus_oe stays 0.
- Read: ne=0, addr=8'h34, noe low 12 clk; bench acks 3 clk after reg_rd with reg_rdata=16'h1357 -> bus_dout=1357; bus_oe rises 1 clk later; bus_oe falls within 4 clk of noe rising.
- Illegal: noe and nwe driven low together with ne=0 -> single proto_err pulse; no reg_wr or reg_rd; bus_oe=0.
- Abort: ne rises while in WR_WAIT (WR_DLY=7) -> no reg_wr; state returns IDLE; next normal write succeeds.
- Reset mid-read: assert rst while bus_oe=1 -> bus_oe=0 and all outputs 0 immediately (async); after release, a read of addr 8'h01 completes normally.
- Timeout (macro defined, RD_TIMEOUT=64): read with no reg_rack -> after 64 clk, bus_dout=16'hFFFF, proto_err pulses, bus_oe=1 until noe rises.
